wm_multikey_scan: RTL and testbench

- Next-generation Wu-Manber compare stage for the NIDS datapath.
- Accepts one message window via a valid/ready handshake.
- Sequentially evaluates that window against up to NOS_KEY patterns, one key per cycle, under a per-window key-enable mask.
- Returns the minimum safe shift across all enabled keys, a complete-match flag and the index of the first matching key, held until the downstream consumer accepts it.

---
 rtl/wm_multikey_scan.sv | 175 +++++++++++++++++
 tb/tb_wm_multikey_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_multikey_scan.sv
// Wu-Manber compare stage: scans one window against NOS_KEY patterns, one key per cycle.
// Optional saturating complete-match counter enabled by defining WM_MATCH_COUNT_EN.
module wm_multikey_scan #(
   parameter int MSG_WIDTH     = 8,
   parameter int B             = 3,
   parameter int PATTERN_WIDTH = 6,
   parameter int NOS_KEY       = 4,
   parameter int SHIFT_WIDTH   = $clog2(PATTERN_WIDTH-B+2),
   parameter int KEY_IDX_WIDTH = $clog2(NOS_KEY)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [MSG_WIDTH*PATTERN_WIDTH-1:0]         data_in,
   input  logic [NOS_KEY-1:0]                         key_mask,
   input  logic [MSG_WIDTH*PATTERN_WIDTH*NOS_KEY-1:0] patterns,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [SHIFT_WIDTH-1:0]                     shift_amount,
   output logic                                       complete_match,
   output logic [KEY_IDX_WIDTH-1:0]                   match_key
`ifdef WM_MATCH_COUNT_EN
   ,
   input  logic                                       clear_count,
   output logic [15:0]                                match_count
`endif
);

   localparam int WIN_W = MSG_WIDTH*PATTERN_WIDTH;
   localparam int BLK_W = MSG_WIDTH*B;
   localparam logic [SHIFT_WIDTH-1:0]   NO_SHIFT = SHIFT_WIDTH'(PATTERN_WIDTH-B+1);
   localparam logic [KEY_IDX_WIDTH-1:0] LAST_KEY = KEY_IDX_WIDTH'(NOS_KEY-1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [KEY_IDX_WIDTH-1:0] key_q, key_d;
   logic [WIN_W-1:0]         win_q, win_d;
   logic [NOS_KEY-1:0]       mask_q, mask_d;
   logic [SHIFT_WIDTH-1:0]   min_q, min_d;
   logic                     hit_q, hit_d;
   logic [KEY_IDX_WIDTH-1:0] hit_key_q, hit_key_d;
   logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
   logic                     cm_q, cm_d;
   logic [KEY_IDX_WIDTH-1:0] mk_q, mk_d;

   logic [WIN_W-1:0]         cur_pat;
   logic [SHIFT_WIDTH-1:0]   part_shift;
   logic                     full_hit;
   logic                     key_en;

   // Smallest offset j at which the window's leading block appears inside the pattern.
   function automatic logic [SHIFT_WIDTH-1:0] partial_shift(input logic [WIN_W-1:0] win,
                                                            input logic [WIN_W-1:0] pat);
      logic [SHIFT_WIDTH-1:0] s;
      s = NO_SHIFT;
      for (int j = PATTERN_WIDTH-B; j >= 1; j--) begin
         if (pat[j*MSG_WIDTH +: BLK_W] == win[BLK_W-1:0]) s = SHIFT_WIDTH'(j);
      end
      return s;
   endfunction

   always_comb begin
      cur_pat = '0;
      for (int k = 0; k < NOS_KEY; k++) begin
         if (key_q == KEY_IDX_WIDTH'(k)) cur_pat = patterns[k*WIN_W +: WIN_W];
      end
   end

   assign part_shift = partial_shift(win_q, cur_pat);
   assign full_hit   = (cur_pat == win_q);
   assign key_en     = mask_q[key_q];

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      win_d     = win_q;
      mask_d    = mask_q;
      min_d     = min_q;
      hit_d     = hit_q;
      hit_key_d = hit_key_q;
      shift_d   = shift_q;
      cm_d      = cm_q;
      mk_d      = mk_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = reset;
            if (in_valid && in_ready) begin
               win_d     = data_in;
               mask_d    = key_mask;
               min_d     = NO_SHIFT;
               hit_d     = 1'b0;
               hit_key_d = '0;
               key_d     = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (key_en && (part_shift < min_q)) min_d = part_shift;
            if (key_en && full_hit && !hit_q) begin
               hit_d     = 1'b1;
               hit_key_d = key_q;
            end
            if (key_q == LAST_KEY) begin
               // Results are published only here so they stay frozen through IDLE/SCAN.
               key_d   = '0;
               shift_d = min_d;
               cm_d    = hit_d;
               mk_d    = hit_key_d;
               state_d = DONE;
            end else begin
               key_d = key_q + KEY_IDX_WIDTH'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         key_q     <= '0;
         win_q     <= '0;
         mask_q    <= '0;
         min_q     <= NO_SHIFT;
         hit_q     <= 1'b0;
         hit_key_q <= '0;
         shift_q   <= NO_SHIFT;
         cm_q      <= 1'b0;
         mk_q      <= '0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         win_q     <= win_d;
         mask_q    <= mask_d;
         min_q     <= min_d;
         hit_q     <= hit_d;
         hit_key_q <= hit_key_d;
         shift_q   <= shift_d;
         cm_q      <= cm_d;
         mk_q      <= mk_d;
      end
   end

   assign shift_amount   = shift_q;
   assign complete_match = cm_q;
   assign match_key      = mk_q;

`ifdef WM_MATCH_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_count)
         count_d = '0;
      else if (out_valid && out_ready && cm_q && (count_q != 16'hFFFF))
         count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign match_count = count_q;
`endif

endmodule

// File: tb/tb_wm_multikey_scan.sv
// Directed plus randomized bench for wm_multikey_scan against a string-level reference model.
module tb_wm_multikey_scan;
   localparam int MW = 8;
   localparam int B  = 3;
   localparam int PW = 6;
   localparam int NK = 4;
   localparam int SW = $clog2(PW-B+2);
   localparam int KW = $clog2(NK);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [MW*PW-1:0]    data_in;
   logic [NK-1:0]       key_mask;
   logic [MW*PW*NK-1:0] patterns;
   logic                out_valid;
   logic                out_ready;
   logic [SW-1:0]       shift_amount;
   logic                complete_match;
   logic [KW-1:0]       match_key;
`ifdef WM_MATCH_COUNT_EN
   logic                clear_count;
   logic [15:0]         match_count;
`endif

   wm_multikey_scan #(.MSG_WIDTH(MW), .B(B), .PATTERN_WIDTH(PW), .NOS_KEY(NK)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .data_in        (data_in),
      .key_mask       (key_mask),
      .patterns       (patterns),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .shift_amount   (shift_amount),
      .complete_match (complete_match),
      .match_key      (match_key)
`ifdef WM_MATCH_COUNT_EN
      ,
      .clear_count    (clear_count),
      .match_count    (match_count)
`endif
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   string pat_s [NK];
   int    prev_sh  = PW-B+1;
   int    prev_cm  = 0;
   int    prev_mk  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW*PW-1:0] pack(input string s);
      logic [MW*PW-1:0] v;
      for (int i = 0; i < PW; i++) v[i*MW +: MW] = s[i];
      return v;
   endfunction

   task automatic load_pats();
      for (int k = 0; k < NK; k++) patterns[k*MW*PW +: MW*PW] = pack(pat_s[k]);
   endtask

   // Reference: minimum over enabled keys of the first offset where the window prefix reappears.
   function automatic void model(input string w, input logic [NK-1:0] m,
                                 output int sh, output int cm, output int mk);
      sh = PW-B+1; cm = 0; mk = 0;
      for (int k = 0; k < NK; k++) begin
         if (m[k]) begin
            int ps;
            ps = PW-B+1;
            for (int j = PW-B; j >= 1; j--)
               if (pat_s[k].substr(j, j+B-1) == w.substr(0, B-1)) ps = j;
            if (ps < sh) sh = ps;
            if (cm == 0 && pat_s[k] == w) begin
               cm = 1;
               mk = k;
            end
         end
      end
   endfunction

   function automatic string rand_str(input string alpha);
      string s;
      s = "______";
      for (int i = 0; i < PW; i++) s.putc(i, alpha[$urandom_range(0, alpha.len()-1)]);
      return s;
   endfunction

   task automatic run(input string tag, input string w, input logic [NK-1:0] m, input int hold);
      int sh, cm, mk, lat;
      bit seen;
      model(w, m, sh, cm, mk);
      data_in  = pack(w);
      key_mask = m;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      check({tag, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      data_in  = $urandom;
      key_mask = NK'($urandom);
      in_valid = 1'b1;
      check({tag, " held_shift"}, shift_amount, prev_sh);
      check({tag, " held_cm"}, complete_match, prev_cm);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) seen = 1'b1;
         else check({tag, " scan_in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      check({tag, " latency"}, lat, NK+1);
      check({tag, " shift"}, shift_amount, sh);
      check({tag, " complete_match"}, complete_match, cm);
      check({tag, " match_key"}, match_key, mk);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         @(posedge clk); #1;
         check({tag, " bp_valid"}, out_valid, 1);
         check({tag, " bp_in_ready"}, in_ready, 0);
         check({tag, " bp_shift"}, shift_amount, sh);
         check({tag, " bp_cm"}, complete_match, cm);
         check({tag, " bp_key"}, match_key, mk);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " release_valid"}, out_valid, 0);
      check({tag, " release_in_ready"}, in_ready, 1);
      prev_sh = sh;
      prev_cm = cm;
      prev_mk = mk;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      key_mask  = '0;
      patterns  = '0;
`ifdef WM_MATCH_COUNT_EN
      clear_count = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst shift", shift_amount, PW-B+1);
      check("rst cm", complete_match, 0);
      check("rst key", match_key, 0);
      check("rst in_ready", in_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst in_ready", in_ready, 1);
      check("post_rst out_valid", out_valid, 0);

      pat_s[0] = "ABCDEF"; pat_s[1] = "ZZZZZZ"; pat_s[2] = "ZZZZZZ"; pat_s[3] = "ZZZZZZ";
      load_pats();
      run("partial", "BCDxyz", 4'b1111, 0);

      pat_s[0] = "ZZZZZZ"; pat_s[1] = "QQQBCD"; pat_s[2] = "QBCDQQ"; pat_s[3] = "ZZZZZZ";
      load_pats();
      run("multimin", "BCD___", 4'b1111, 1);
      run("multimin_mask", "BCD___", 4'b1011, 0);

      pat_s[0] = "ZZZZZZ"; pat_s[1] = "HELLO!"; pat_s[2] = "ZZZZZZ"; pat_s[3] = "HELLO!";
      load_pats();
      run("dup_masked", "HELLO!", 4'b0101, 0);
      run("dup_match", "HELLO!", 4'b1111, 10);

      // Abort a scan two cycles in with an asynchronous reset.
      data_in  = pack("HELLO!");
      key_mask = 4'b1111;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst shift", shift_amount, PW-B+1);
      check("midrst cm", complete_match, 0);
      check("midrst key", match_key, 0);
      check("midrst in_ready", in_ready, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("midrst hold_valid", out_valid, 0);
      end
      reset   = 1'b1;
      prev_sh = PW-B+1;
      prev_cm = 0;
      prev_mk = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("after_rst no_valid", out_valid, 0);
      end
      pat_s[0] = "ABCDEF"; pat_s[1] = "ZZZZZZ"; pat_s[2] = "ZZZZZZ"; pat_s[3] = "ZZZZZZ";
      load_pats();
      run("after_rst", "BCDxyz", 4'b1111, 0);

      for (int n = 0; n < 40; n++) begin
         string w;
         for (int k = 0; k < NK; k++) pat_s[k] = rand_str("AB");
         load_pats();
         if ($urandom_range(0, 2) == 0) w = pat_s[$urandom_range(0, NK-1)];
         else                           w = rand_str("AB");
         run($sformatf("rand%0d", n), w, NK'($urandom), $urandom_range(0, 2));
      end

`ifdef WM_MATCH_COUNT_EN
      clear_count = 1'b1;
      @(posedge clk); #1;
      clear_count = 1'b0;
      check("count cleared", match_count, 0);
      pat_s[0] = "ZZZZZZ"; pat_s[1] = "HELLO!"; pat_s[2] = "ZZZZZZ"; pat_s[3] = "HELLO!";
      load_pats();
      for (int n = 0; n < 3; n++) run("count_win", "HELLO!", 4'b1111, 0);
      check("count three", match_count, 3);
      clear_count = 1'b1;
      @(posedge clk); #1;
      clear_count = 1'b0;
      check("count clear_again", match_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
